// File: rtl/snoop_host_pkg.sv
// Shared opcodes and FSM state encoding for the discus snoop-port host master.
package snoop_host_pkg;

  localparam logic [7:0] OP_MEMW  = 8'h4D;
  localparam logic [7:0] OP_PRGW  = 8'h50;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_IDENT = 8'h49;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_LEN,
    WDATA,
    RD_WAIT,
    RD_CAP,
    SEND
  } state_t;

endpackage

// File: rtl/snoop_host.sv
// Byte-stream command decoder driving the discus snoop port: memory/program
// writes, data-memory reads and target identification.
module snoop_host
  import snoop_host_pkg::*;
#(
  parameter logic [7:0]  ID_BYTE = 8'h44,
  parameter int unsigned TIMEOUT = 0,
  parameter int          TO_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  input  logic [7:0] snoopq,
  output logic       snoopm,
  output logic       snoopp,
  output logic       busy,
  output logic       cmd_error
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [7:0]      addr;
  logic [7:0]      cnt;
  logic            is_prg;
  logic            is_read;
  logic [TO_W-1:0] to_cnt;
  logic            accept;
  logic            collecting;
  logic            to_expire;

  assign collecting = (state == GET_ADDR) || (state == GET_LEN) || (state == WDATA);
  assign in_ready   = rst_n && ((state == IDLE) || collecting);
  assign accept     = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign to_expire  = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      is_prg    <= 1'b0;
      is_read   <= 1'b0;
      to_cnt    <= '0;
      snoopa    <= '0;
      snoopd    <= '0;
      snoopm    <= 1'b0;
      snoopp    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      snoopm    <= 1'b0;
      snoopp    <= 1'b0;
      cmd_error <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            case (in_data)
              OP_MEMW: begin
                is_prg  <= 1'b0;
                is_read <= 1'b0;
                state   <= GET_ADDR;
              end
              OP_PRGW: begin
                is_prg  <= 1'b1;
                is_read <= 1'b0;
                state   <= GET_ADDR;
              end
              OP_READ: begin
                is_read <= 1'b1;
                state   <= GET_ADDR;
              end
              OP_IDENT: begin
                out_data  <= ID_BYTE;
                out_valid <= 1'b1;
                cnt       <= '0;
                state     <= SEND;
              end
              default: cmd_error <= 1'b1;
            endcase
          end
        end

        GET_ADDR: begin
          if (accept) begin
            addr  <= in_data;
            state <= GET_LEN;
          end
        end

        GET_LEN: begin
          if (accept) begin
            cnt <= in_data;
            if (is_read) begin
              snoopa <= addr;
              state  <= RD_WAIT;
            end else begin
              state <= WDATA;
            end
          end
        end

        WDATA: begin
          if (accept) begin
            snoopa <= addr;
            snoopd <= in_data;
            snoopm <= !is_prg;
            snoopp <= is_prg;
            addr   <= addr + 8'd1;
            if (cnt == 8'd0) state <= IDLE;
            else             cnt   <= cnt - 8'd1;
          end
        end

        RD_WAIT: state <= RD_CAP;

        RD_CAP: begin
          out_data  <= snoopq;
          out_valid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cnt == 8'd0) begin
              state <= IDLE;
            end else begin
              addr   <= addr + 8'd1;
              cnt    <= cnt - 8'd1;
              snoopa <= addr + 8'd1;
              state  <= RD_WAIT;
            end
          end
        end

        default: state <= IDLE;
      endcase

      // Idle input only counts mid-command; an accept in the expiring cycle wins.
      if (collecting && !accept) begin
        if (to_expire) begin
          state     <= IDLE;
          cmd_error <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_snoop_host.sv
// Directed bench for snoop_host: write/read/identify/error commands against a
// simple registered data-memory model behind the snoop pins.
module tb_snoop_host;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] snoopa;
  logic [7:0] snoopd;
  logic [7:0] snoopq;
  logic       snoopm;
  logic       snoopp;
  logic       busy;
  logic       cmd_error;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_acc_cyc = 0;
  int first_valid_cyc = -1;

  logic [7:0] mem [0:255];

  logic [7:0] wr_addr [0:299];
  logic [7:0] wr_data [0:299];
  logic       wr_prg  [0:299];
  int         wr_n = 0;

  logic [7:0] rx_data [0:299];
  int         rx_cyc  [0:299];
  int         rx_n = 0;

  int         err_n = 0;
  logic       hold_chk = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  snoop_host #(.ID_BYTE(8'h44), .TIMEOUT(8), .TO_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .snoopa    (snoopa),
    .snoopd    (snoopd),
    .snoopq    (snoopq),
    .snoopm    (snoopm),
    .snoopp    (snoopp),
    .busy      (busy),
    .cmd_error (cmd_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered data memory: read data follows snoopa by one cycle.
  always @(posedge clk) begin
    if (snoopm) mem[snoopa] <= snoopd;
    snoopq <= mem[snoopa];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (snoopm || snoopp) begin
      checkOutput("strobe_excl", 32'(snoopm & snoopp), 0);
      if (wr_n < 300) begin
        wr_addr[wr_n] = snoopa;
        wr_data[wr_n] = snoopd;
        wr_prg[wr_n]  = snoopp;
      end
      wr_n++;
    end
    if (cmd_error) err_n++;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (hold_chk && prev_hold) begin
      checkOutput("hold_valid", 32'(out_valid), 1);
      checkOutput("hold_data", 32'(out_data), 32'(prev_data));
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    if (out_valid && out_ready) begin
      if (rx_n < 300) begin
        rx_data[rx_n] = out_data;
        rx_cyc[rx_n]  = cyc;
      end
      rx_n++;
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("in_ready_wait", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic waitRx(input int n);
    for (int i = 0; i < 1200 && rx_n < n; i++) @(posedge clk);
    #1;
    if (rx_n < n) checkOutput("rx_timeout", 32'(rx_n), 32'(n));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b1;

    // Reset and idle state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready_low", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_snoopa", 32'(snoopa), 0);
    checkOutput("rst_snoopd", 32'(snoopd), 0);
    checkOutput("rst_strobes", 32'({snoopm, snoopp}), 0);
    checkOutput("rst_out", 32'({out_valid, out_data}), 0);
    checkOutput("rst_cmd_error", 32'(cmd_error), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Program write: 50 10 02 AA BB CC
    wr_n = 0;
    applyStimulus(8'h50);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    @(negedge clk);
    checkOutput("prg_busy_drop", 32'(busy), 0);
    idleCycles(3);
    checkOutput("prg_count", 32'(wr_n), 3);
    checkOutput("prg_w0", 32'({wr_prg[0], wr_addr[0], wr_data[0]}), 32'h1_10AA);
    checkOutput("prg_w1", 32'({wr_prg[1], wr_addr[1], wr_data[1]}), 32'h1_11BB);
    checkOutput("prg_w2", 32'({wr_prg[2], wr_addr[2], wr_data[2]}), 32'h1_12CC);

    // Memory write wrapping past FF
    wr_n = 0;
    applyStimulus(8'h4D);
    applyStimulus(8'hFE);
    applyStimulus(8'h02);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    idleCycles(3);
    checkOutput("wrap_count", 32'(wr_n), 3);
    checkOutput("wrap_w0", 32'({wr_prg[0], wr_addr[0], wr_data[0]}), 32'h0_FE01);
    checkOutput("wrap_w1", 32'({wr_prg[1], wr_addr[1], wr_data[1]}), 32'h0_FF02);
    checkOutput("wrap_w2", 32'({wr_prg[2], wr_addr[2], wr_data[2]}), 32'h0_0003);

    // Wrapping read with out_ready toggling
    rx_n = 0;
    hold_chk = 1'b1;
    applyStimulus(8'h52);
    applyStimulus(8'hFE);
    applyStimulus(8'h02);
    for (int i = 0; i < 80 && rx_n < 3; i++) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    hold_chk = 1'b0;
    idleCycles(4);
    checkOutput("wrap_rd_count", 32'(rx_n), 3);
    checkOutput("wrap_rd0", 32'(rx_data[0]), 32'h01);
    checkOutput("wrap_rd1", 32'(rx_data[1]), 32'h02);
    checkOutput("wrap_rd2", 32'(rx_data[2]), 32'h03);
    checkOutput("wrap_rd_busy", 32'(busy), 0);

    // Fill all of data memory with addr ^ 5A using a 256-byte write
    wr_n = 0;
    applyStimulus(8'h4D);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    for (int i = 0; i < 256; i++) applyStimulus(8'(i) ^ 8'h5A);
    idleCycles(3);
    checkOutput("fill_count", 32'(wr_n), 256);
    checkOutput("fill_last", 32'({wr_addr[255], wr_data[255]}), 32'hFFA5);
    checkOutput("fill_busy", 32'(busy), 0);

    // 256-byte read: latency 2, one byte per 3 cycles
    rx_n = 0;
    applyStimulus(8'h52);
    applyStimulus(8'h00);
    first_valid_cyc = -1;
    applyStimulus(8'hFF);
    waitRx(256);
    idleCycles(3);
    checkOutput("rd256_count", 32'(rx_n), 256);
    checkOutput("rd256_latency", 32'(first_valid_cyc - last_acc_cyc), 2);
    checkOutput("rd256_spacing", 32'(rx_cyc[1] - rx_cyc[0]), 3);
    checkOutput("rd256_span", 32'(rx_cyc[255] - rx_cyc[0]), 765);
    for (int i = 0; i < 256; i++) checkOutput("rd256_data", 32'(rx_data[i]), 32'(8'(i) ^ 8'h5A));
    checkOutput("rd256_last", 32'(rx_data[255]), 32'hA5);
    checkOutput("rd256_busy", 32'(busy), 0);

    // Identify
    rx_n = 0;
    applyStimulus(8'h49);
    waitRx(1);
    idleCycles(2);
    checkOutput("ident_count", 32'(rx_n), 1);
    checkOutput("ident_byte", 32'(rx_data[0]), 32'h44);
    checkOutput("ident_busy", 32'(busy), 0);

    // Unknown opcode
    rx_n = 0;
    err_n = 0;
    applyStimulus(8'h7E);
    idleCycles(4);
    checkOutput("badop_err_cycles", 32'(err_n), 1);
    checkOutput("badop_no_output", 32'(rx_n), 0);
    checkOutput("badop_idle", 32'({busy, in_ready}), 32'b01);

    // Timeout boundary: accept on the 8th idle cycle beats the timeout
    err_n = 0;
    wr_n = 0;
    applyStimulus(8'h4D);
    idleCycles(7);
    applyStimulus(8'h30);
    applyStimulus(8'h00);
    applyStimulus(8'h77);
    idleCycles(2);
    checkOutput("to_edge_no_err", 32'(err_n), 0);
    checkOutput("to_edge_write", 32'({wr_n[7:0], wr_addr[0], wr_data[0]}), 32'h01_3077);

    // Timeout: 4D 20 then 8 idle cycles
    err_n = 0;
    applyStimulus(8'h4D);
    applyStimulus(8'h20);
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkOutput("to_before", 32'({busy, cmd_error}), 32'b10);
    @(posedge clk);
    @(negedge clk);
    checkOutput("to_fire", 32'({busy, cmd_error}), 32'b01);
    idleCycles(2);
    checkOutput("to_err_cycles", 32'(err_n), 1);
    rx_n = 0;
    applyStimulus(8'h49);
    waitRx(1);
    checkOutput("to_ident", 32'(rx_data[0]), 32'h44);
    idleCycles(2);

    // Reset in WDATA the cycle after an accept
    wr_n = 0;
    applyStimulus(8'h4D);
    applyStimulus(8'h40);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    checkOutput("rstmid_strobe_pre", 32'(snoopm), 1);
    rst_n = 1'b0;
    in_data = 8'h22;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstmid_snoopm", 32'(snoopm), 0);
    checkOutput("rstmid_busy", 32'(busy), 0);
    checkOutput("rstmid_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    idleCycles(4);
    checkOutput("rstmid_writes", 32'(wr_n), 1);
    checkOutput("rstmid_out_valid", 32'(out_valid), 0);
    checkOutput("rstmid_in_ready_after", 32'(in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
